// File: rtl/register_bank_pkg.sv
// Shared types and helpers for the register_bank slice: FSM states, access modes,
// per-index mode lookup and byte-strobe expansion.
package register_bank_pkg;

    typedef enum logic {IDLE, RESP} state_e;

    typedef enum logic [1:0] {MODE_RW, MODE_RO, MODE_W1C} mode_e;

    localparam int MAX_REGS  = 256;
    localparam int MAX_BYTES = 128;

    // Read-only wins when a register is flagged both read-only and write-1-to-clear.
    function automatic mode_e getMode(input logic [MAX_REGS-1:0] roMask,
                                      input logic [MAX_REGS-1:0] w1cMask,
                                      input int idx);
        if (roMask[idx]) begin
            return MODE_RO;
        end else if (w1cMask[idx]) begin
            return MODE_W1C;
        end
        return MODE_RW;
    endfunction

    function automatic logic [MAX_BYTES*8-1:0] expandStrobe(input logic [MAX_BYTES-1:0] strobe);
        logic [MAX_BYTES*8-1:0] mask;
        mask = '0;
        for (int b = 0; b < MAX_BYTES; b++) begin
            mask[b*8 +: 8] = {8{strobe[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/register_bank_cell.sv
// One storage register of the bank; MODE selects RW byte-merge, RO pass-through
// of the hardware value, or W1C sticky set / software clear.
module register_bank_cell
    import register_bank_pkg::*;
#(
    parameter int                     BUSWIDTH  = 32,
    parameter mode_e                  MODE      = MODE_RW,
    parameter logic [BUSWIDTH-1:0]    RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                writeEn_i,
    input  logic [BUSWIDTH-1:0] wdata_i,
    input  logic [BUSWIDTH-1:0] bitMask_i,
    input  logic [BUSWIDTH-1:0] hwIn_i,
    output logic [BUSWIDTH-1:0] value_o
);

    logic [BUSWIDTH-1:0] value_q, value_d;
    logic [BUSWIDTH-1:0] clearBits;

    // W1C ORs the hardware set in after the clear, so a simultaneous set wins.
    always_comb begin
        value_d   = value_q;
        clearBits = writeEn_i ? (wdata_i & bitMask_i) : '0;
        if (MODE == MODE_RW) begin
            if (writeEn_i) begin
                value_d = (value_q & ~bitMask_i) | (wdata_i & bitMask_i);
            end
        end else if (MODE == MODE_W1C) begin
            value_d = (value_q & ~clearBits) | hwIn_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= RESET_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = (MODE == MODE_RO) ? hwIn_i : value_q;

endmodule

// File: rtl/register_bank.sv
// Bus-addressed register bank with valid/ready request and response channels.
// Optional write lock input is enabled by defining REGISTER_BANK_LOCK_EN.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int                          BUSWIDTH     = 32,
    parameter int                          REGS         = 8,
    parameter int                          ADDRESSWIDTH = $clog2(REGS),
    parameter logic [REGS-1:0]             RO_MASK      = '0,
    parameter logic [REGS-1:0]             W1C_MASK     = '0,
    parameter logic [REGS*BUSWIDTH-1:0]    RESET_VALUE  = '0
) (
    input  logic                       clk,
    input  logic                       reset,
`ifdef REGISTER_BANK_LOCK_EN
    input  logic                       lock,
`endif
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDRESSWIDTH-1:0]    req_addr,
    input  logic [BUSWIDTH-1:0]        req_wdata,
    input  logic [BUSWIDTH/8-1:0]      req_strobe,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [BUSWIDTH-1:0]        rsp_rdata,
    output logic                       rsp_error,
    input  logic [REGS*BUSWIDTH-1:0]   hw_in,
    output logic [REGS*BUSWIDTH-1:0]   reg_out,
    output logic [REGS-1:0]            write_pulse,
    output logic [REGS-1:0]            read_pulse
);

    state_e              state_q, state_d;
    logic                accept, addrOk, illegalWrite, reqError, lockActive;
    logic [REGS-1:0]     sel, isRo;
    logic [BUSWIDTH-1:0] bitMask, readMux;
    logic [BUSWIDTH-1:0] cellValue [REGS];
    logic [BUSWIDTH-1:0] rdata_q, rdata_d;
    logic                error_q, error_d;
    logic [REGS-1:0]     wpulse_q, wpulse_d, rpulse_q, rpulse_d;

`ifdef REGISTER_BANK_LOCK_EN
    assign lockActive = lock;
`else
    assign lockActive = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE) && !reset;
        rsp_valid = (state_q == RESP);
    end

    assign accept  = req_valid && req_ready;
    assign bitMask = BUSWIDTH'(expandStrobe(MAX_BYTES'(req_strobe)));

    // An address matching no slot leaves sel empty, which is the bad-address error.
    always_comb begin
        sel     = '0;
        readMux = '0;
        for (int i = 0; i < REGS; i++) begin
            if (req_addr == ADDRESSWIDTH'(i)) begin
                sel[i]  = 1'b1;
                readMux = cellValue[i];
            end
        end
        addrOk       = |sel;
        illegalWrite = req_write && ((|(sel & isRo)) || lockActive);
        reqError     = !addrOk || illegalWrite;
    end

    always_comb begin
        rdata_d  = rdata_q;
        error_d  = error_q;
        wpulse_d = '0;
        rpulse_d = '0;
        if (accept) begin
            error_d = reqError;
            rdata_d = (req_write || reqError) ? '0 : readMux;
            if (!reqError) begin
                if (req_write) wpulse_d = sel;
                else           rpulse_d = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= '0;
            error_q  <= 1'b0;
            wpulse_q <= '0;
            rpulse_q <= '0;
        end else begin
            rdata_q  <= rdata_d;
            error_q  <= error_d;
            wpulse_q <= wpulse_d;
            rpulse_q <= rpulse_d;
        end
    end

    assign rsp_rdata   = rdata_q;
    assign rsp_error   = error_q;
    assign write_pulse = wpulse_q;
    assign read_pulse  = rpulse_q;

    // The next write pulse doubles as the cell's commit enable.
    for (genvar i = 0; i < REGS; i++) begin : gCell
        localparam mode_e CellMode = getMode(MAX_REGS'(RO_MASK), MAX_REGS'(W1C_MASK), i);
        assign isRo[i] = (CellMode == MODE_RO);
        register_bank_cell #(
            .BUSWIDTH  (BUSWIDTH),
            .MODE      (CellMode),
            .RESET_VAL (RESET_VALUE[i*BUSWIDTH +: BUSWIDTH])
        ) uCell (
            .clk       (clk),
            .reset     (reset),
            .writeEn_i (wpulse_d[i]),
            .wdata_i   (req_wdata),
            .bitMask_i (bitMask),
            .hwIn_i    (hw_in[i*BUSWIDTH +: BUSWIDTH]),
            .value_o   (cellValue[i])
        );
        assign reg_out[i*BUSWIDTH +: BUSWIDTH] = cellValue[i];
    end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a transaction-level model.
module tb_register_bank;

    localparam int BW = 32;
    localparam int NR = 6;
    localparam int AW = 3;
    localparam logic [NR-1:0]    RO_M  = 6'b101000;
    localparam logic [NR-1:0]    W1C_M = 6'b100100;
    localparam logic [NR*BW-1:0] RV    = {32'h0000_0000, 32'h5A5A_0000, 32'hFFFF_0000,
                                          32'h0000_0000, 32'h0000_00A5, 32'h0000_0011};

    logic            clk;
    logic            reset;
    logic            req_valid, req_ready, req_write;
    logic [AW-1:0]   req_addr;
    logic [BW-1:0]   req_wdata;
    logic [BW/8-1:0] req_strobe;
    logic            rsp_valid, rsp_ready, rsp_error;
    logic [BW-1:0]   rsp_rdata;
    logic [NR*BW-1:0] hw_in, reg_out;
    logic [NR-1:0]   write_pulse, read_pulse;
`ifdef REGISTER_BANK_LOCK_EN
    logic            lock;
`endif

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 0;

    register_bank #(
        .BUSWIDTH(BW), .REGS(NR), .ADDRESSWIDTH(AW),
        .RO_MASK(RO_M), .W1C_MASK(W1C_M), .RESET_VALUE(RV)
    ) dut (
        .clk(clk), .reset(reset),
`ifdef REGISTER_BANK_LOCK_EN
        .lock(lock),
`endif
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strobe(req_strobe),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .hw_in(hw_in), .reg_out(reg_out),
        .write_pulse(write_pulse), .read_pulse(read_pulse)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: one outstanding request, stored register values per index.
    logic [BW-1:0] mReg [NR];
    bit            mBusy;
    logic [BW-1:0] mRd;
    bit            mErr;
    logic [NR-1:0] mWp, mRp;

    always @(posedge clk) begin
        bit  acc, err, lockNow, clr;
        int  a;
`ifdef REGISTER_BANK_LOCK_EN
        lockNow = (lock === 1'b1);
`else
        lockNow = 0;
`endif
        if (reset) begin
            mBusy = 0; mWp = '0; mRp = '0; mRd = '0; mErr = 0;
            for (int i = 0; i < NR; i++) mReg[i] = RV[i*BW +: BW];
        end else begin
            acc = !mBusy && req_valid;
            a   = int'(req_addr);
            err = 0;
            mWp = '0; mRp = '0;
            if (mBusy && rsp_ready) mBusy = 0;
            if (acc) begin
                if (a >= NR) err = 1;
                else if (req_write && (RO_M[a] || lockNow)) err = 1;
                mErr = err;
                if (err || req_write) mRd = '0;
                else if (RO_M[a])     mRd = hw_in[a*BW +: BW];
                else                  mRd = mReg[a];
                if (!err) begin
                    if (req_write) mWp[a] = 1'b1;
                    else           mRp[a] = 1'b1;
                end
                mBusy = 1;
            end
            for (int i = 0; i < NR; i++) begin
                if (RO_M[i]) continue;
                if (W1C_M[i]) begin
                    for (int b = 0; b < BW; b++) begin
                        clr = acc && !err && req_write && (a == i) && req_strobe[b/8] && req_wdata[b];
                        if (hw_in[i*BW + b])  mReg[i][b] = 1'b1;
                        else if (clr)         mReg[i][b] = 1'b0;
                    end
                end else if (acc && !err && req_write && a == i) begin
                    for (int k = 0; k < BW/8; k++)
                        if (req_strobe[k]) mReg[i][k*8 +: 8] = req_wdata[k*8 +: 8];
                end
            end
        end
    end

    // Continuous comparison against the model, just after each active edge.
    always @(posedge clk) begin
        #1;
        if (checkEn) begin
            checkOutput("req_ready", 32'(req_ready), 32'(!mBusy && !reset));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(mBusy));
            if (mBusy) begin
                checkOutput("rsp_rdata", rsp_rdata, mRd);
                checkOutput("rsp_error", 32'(rsp_error), 32'(mErr));
            end
            checkOutput("write_pulse", 32'(write_pulse), 32'(mWp));
            checkOutput("read_pulse", 32'(read_pulse), 32'(mRp));
            for (int i = 0; i < NR; i++)
                checkOutput($sformatf("reg_out[%0d]", i), reg_out[i*BW +: BW],
                            RO_M[i] ? hw_in[i*BW +: BW] : mReg[i]);
        end
    end

    typedef struct {
        bit          write;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] expRdata;
        bit          expErr;
    } vec_t;

    vec_t vecs [20];

    task automatic applyStimulus(input vec_t t);
        logic [NR-1:0] one;
        logic [NR-1:0] expWp, expRp;
        one   = 1;
        expWp = (!t.expErr && t.write)  ? (one << t.addr) : '0;
        expRp = (!t.expErr && !t.write) ? (one << t.addr) : '0;
        @(negedge clk);
        req_valid = 1; req_write = t.write; req_addr = t.addr;
        req_wdata = t.wdata; req_strobe = t.strb; rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        checkOutput($sformatf("vec a%0d rvalid", t.addr), 32'(rsp_valid), 32'd1);
        checkOutput($sformatf("vec a%0d rdata", t.addr), rsp_rdata, t.expRdata);
        checkOutput($sformatf("vec a%0d error", t.addr), 32'(rsp_error), 32'(t.expErr));
        checkOutput($sformatf("vec a%0d wpulse", t.addr), 32'(write_pulse), 32'(expWp));
        checkOutput($sformatf("vec a%0d rpulse", t.addr), 32'(read_pulse), 32'(expRp));
        @(posedge clk);
    endtask

    initial begin
        reset = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        req_strobe = '0; rsp_ready = 1; hw_in = '0;
`ifdef REGISTER_BANK_LOCK_EN
        lock = 0;
`endif
        hw_in[0*BW +: BW] = 32'hAAAA_AAAA;
        hw_in[3*BW +: BW] = 32'h1234_5678;
        hw_in[4*BW +: BW] = 32'hFFFF_FFFF;
        hw_in[5*BW +: BW] = 32'h0F0F_0F0F;

        vecs[0]  = '{0, 3'd0, 32'h0, 4'h0, 32'h0000_0011, 0};
        vecs[1]  = '{0, 3'd1, 32'h0, 4'h0, 32'h0000_00A5, 0};
        vecs[2]  = '{0, 3'd2, 32'h0, 4'h0, 32'h0000_0000, 0};
        vecs[3]  = '{0, 3'd3, 32'h0, 4'h0, 32'h1234_5678, 0};
        vecs[4]  = '{0, 3'd4, 32'h0, 4'h0, 32'h5A5A_0000, 0};
        vecs[5]  = '{0, 3'd5, 32'h0, 4'h0, 32'h0F0F_0F0F, 0};
        vecs[6]  = '{1, 3'd0, 32'hDEAD_BEEF, 4'hF, 32'h0, 0};
        vecs[7]  = '{1, 3'd0, 32'h0000_1200, 4'h2, 32'h0, 0};
        vecs[8]  = '{0, 3'd0, 32'h0, 4'h0, 32'hDEAD_12EF, 0};
        vecs[9]  = '{1, 3'd3, 32'hFFFF_FFFF, 4'hF, 32'h0, 1};
        vecs[10] = '{0, 3'd3, 32'h0, 4'h0, 32'h1234_5678, 0};
        vecs[11] = '{1, 3'd5, 32'h0000_0001, 4'hF, 32'h0, 1};
        vecs[12] = '{0, 3'd6, 32'h0, 4'h0, 32'h0, 1};
        vecs[13] = '{0, 3'd7, 32'h0, 4'h0, 32'h0, 1};
        vecs[14] = '{1, 3'd6, 32'h1111_1111, 4'hF, 32'h0, 1};
        vecs[15] = '{1, 3'd4, 32'hFFFF_FFFF, 4'h0, 32'h0, 0};
        vecs[16] = '{0, 3'd4, 32'h0, 4'h0, 32'h5A5A_0000, 0};
        vecs[17] = '{1, 3'd1, 32'h0033_3C00, 4'h6, 32'h0, 0};
        vecs[18] = '{0, 3'd1, 32'h0, 4'h0, 32'h0033_3CA5, 0};
        vecs[19] = '{0, 3'd3, 32'h0, 4'h0, 32'h1234_5678, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset pulses", 32'({write_pulse, read_pulse}), 32'd0);
        checkOutput("reset reg0", reg_out[0*BW +: BW], 32'h0000_0011);
        checkEn = 1;
        reset = 0;

        for (int v = 0; v < 20; v++) applyStimulus(vecs[v]);

        // W1C: a one-cycle hardware set sticks until software clears it.
        @(negedge clk); hw_in[2*BW + 3] = 1'b1;
        @(negedge clk); hw_in[2*BW + 3] = 1'b0;
        applyStimulus('{0, 3'd2, 32'h0, 4'h0, 32'h0000_0008, 0});
        applyStimulus('{1, 3'd2, 32'h0000_0008, 4'hF, 32'h0, 0});
        applyStimulus('{0, 3'd2, 32'h0, 4'h0, 32'h0000_0000, 0});
        @(negedge clk);
        hw_in[2*BW + 3] = 1'b1;
        req_valid = 1; req_write = 1; req_addr = 3'd2; req_wdata = 32'h8; req_strobe = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0; hw_in[2*BW + 3] = 1'b0;
        checkOutput("w1c setwins error", 32'(rsp_error), 32'd0);
        @(posedge clk);
        applyStimulus('{0, 3'd2, 32'h0, 4'h0, 32'h0000_0008, 0});
        applyStimulus('{1, 3'd2, 32'h0000_0008, 4'h1, 32'h0, 0});
        applyStimulus('{0, 3'd2, 32'h0, 4'h0, 32'h0000_0000, 0});

        // Response stall with a competing request that must be ignored.
        applyStimulus('{1, 3'd0, 32'h0000_CAFE, 4'hF, 32'h0, 0});
        @(negedge clk);
        rsp_ready = 0; req_valid = 1; req_write = 0; req_addr = 3'd0;
        @(posedge clk);
        @(negedge clk);
        req_write = 1; req_wdata = 32'h0; req_strobe = 4'hF;
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("stall rsp_rdata", rsp_rdata, 32'h0000_CAFE);
            checkOutput("stall req_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 0; rsp_ready = 1;
        @(posedge clk);
        applyStimulus('{0, 3'd0, 32'h0, 4'h0, 32'h0000_CAFE, 0});

        // Reset while a response is pending.
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 3'd0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0; rsp_ready = 0; reset = 1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst reg0", reg_out[0*BW +: BW], 32'h0000_0011);
        checkOutput("rst pulses", 32'({write_pulse, read_pulse}), 32'd0);
        reset = 0; rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post-rst req_ready", 32'(req_ready), 32'd1);

`ifdef REGISTER_BANK_LOCK_EN
        lock = 1;
        applyStimulus('{1, 3'd0, 32'h0000_0001, 4'hF, 32'h0, 1});
        applyStimulus('{0, 3'd0, 32'h0, 4'h0, 32'h0000_0011, 0});
        lock = 0;
`endif

        // Randomized traffic; the model process and continuous checker judge every cycle.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            reset      = ($urandom_range(0, 99) == 0);
            req_valid  = $urandom_range(0, 1) == 1;
            req_write  = $urandom_range(0, 1) == 1;
            req_addr   = AW'($urandom_range(0, 7));
            req_wdata  = $urandom;
            req_strobe = 4'($urandom_range(0, 15));
            rsp_ready  = $urandom_range(0, 3) != 0;
`ifdef REGISTER_BANK_LOCK_EN
            lock       = $urandom_range(0, 3) == 0;
`endif
            for (int i = 0; i < NR; i++) begin
                if (i == 2) hw_in[i*BW +: BW] = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
                else        hw_in[i*BW +: BW] = $urandom;
            end
        end
        @(negedge clk);
        req_valid = 0; reset = 0; rsp_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
